fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single write port of the 32x8 FIFO between NUM_REQ packet sources.
//  Round-robin arbitration at packet granularity: a winner owns the port until its last beat is accepted.
//  Drives the FIFO write_enb/datain pair and honours its full flag; sits between source blocks and the FIFO.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  DATA_W   8   beat width; matches FIFO datain
//  CNT_W    16  width of each per-requester beat counter (stats build only)
// PORTS
//  clk             in   1               rising-edge clock
//  reset_n         in   1               synchronous, active-low reset
//  req             in   NUM_REQ         per-source beat valid; held with data/last until gnt
//  req_data        in   NUM_REQ*DATA_W  flattened beats; source i at [i*DATA_W +: DATA_W]
//  req_last        in   NUM_REQ         final beat of packet
//  gnt             out  NUM_REQ         one-hot; beat of source i accepted this cycle
//  fifo_write_enb  out  1               to FIFO write_enb
//  fifo_datain     out  DATA_W          to FIFO datain
//  fifo_full       in   1               from FIFO full
//  busy            out  1               1 while a packet owns the port (LOCKED)
//  owner           out  $clog2(NUM_REQ) current/most recent owner index
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=IDLE, last_owner=NUM_REQ-1 (so req[0] wins first), busy=0, owner=0.
//    gnt/fifo_write_enb are 0 during reset regardless of inputs; reset mid-packet abandons the packet.
//  - FSM IDLE: if |req, pick first i with req[i]=1 scanning last_owner+1, +2, ... (mod NUM_REQ);
//    owner<=i, go LOCKED. No beat is accepted in IDLE (1-cycle arbitration bubble). fifo_full ignored here.
//  - FSM LOCKED: accept = req[owner] & ~fifo_full (combinational).
//    fifo_write_enb = accept; fifo_datain = req_data[owner] (data valid only with enb);
//    gnt = accept ? (1<<owner) : 0. Zero-latency pass-through: no registers on the data path.
//    accept & req_last[owner]: last_owner<=owner, go IDLE next cycle.
//    req[owner]=0 (gap) or fifo_full=1: stay LOCKED, no write; other sources never preempt.
//  - Last beat while fifo_full=1: not accepted, remains LOCKED until full clears.
//  - Single-beat packet (req_last=1 on first beat): LOCKED for exactly one accepted cycle.
//  - Back-to-back packets: minimum one IDLE cycle between last beat and next packet's first beat.
//  - busy = (state==LOCKED); owner holds its value through IDLE.
//  - Only one write per cycle; FIFO overflow impossible since enb never asserted with full=1.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: adds ports stats_clr (in, 1) and beat_count (out, NUM_REQ*CNT_W).
//    beat_count[i] increments on gnt[i]; saturates at all-ones; reset to 0;
//    stats_clr=1 zeroes all counters next edge and wins over a same-cycle increment.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  - Package fifo_arb_pkg: state encoding localparams (ST_IDLE=1'b0, ST_LOCKED=1'b1), default widths.
//  - Sub-module rr_pick (combinational): inputs req, last_owner; outputs found, winner index.
//  - Top holds FSM, owner/last_owner regs, output muxing, optional counters.
// TESTING
//  1. Reset: reset_n=0 with req=4'b1111 -> gnt=0, fifo_write_enb=0, busy=0, owner=0.
//  2. req=4'b1111, 1-beat packets each, full=0 -> owners 0,1,2,3,0 in order; one IDLE cycle between grants.
//  3. Src2 sends 3-beat packet 0xA1,0xA2,0xA3 while src0 requests -> FIFO sees A1,A2,A3 contiguous, then src0.
//  4. fifo_full=1 for 5 cycles mid-packet -> fifo_write_enb=0, gnt=0, busy=1; resumes with held beat, no loss/dup.
//  5. Owner drops req for 2 cycles mid-packet, src1 requesting -> no preemption, src1 waits until last accepted.
//  6. FIFO_ARB_STATS_EN, CNT_W=4: 20 beats from src1 -> beat_count[1]=15 (saturated); stats_clr -> 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default widths for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after last_owner, wrapping mod NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        // k runs 1..NUM_REQ so last_owner itself is considered last
        for (int unsigned k = 1; k <= 32'(NUM_REQ); k++) begin
            cand = IDX_W'((32'(last_owner) + k) % 32'(NUM_REQ));
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-granular round-robin arbiter for the FIFO write port.
// Optional per-source beat counters when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
`ifdef FIFO_ARB_STATS_EN
    ,
    parameter int CNT_W   = DEF_CNT_W
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        fifo_write_enb,
    output logic [DATA_W-1:0]           fifo_datain,
    input  logic                        fifo_full,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                        stats_clr,
    output logic [NUM_REQ*CNT_W-1:0]    beat_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] last_owner, last_owner_nxt;
    logic             found;
    logic [IDX_W-1:0] winner;
    logic             accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .found      (found),
        .winner     (winner)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // reset_n gates accept so nothing is written while reset is held mid-packet
    assign accept = reset_n && (state == ST_LOCKED) && req[owner] && !fifo_full;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        unique case (state)
            ST_IDLE: begin
                if (found) begin
                    owner_nxt = winner;
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept && req_last[owner]) begin
                    last_owner_nxt = owner;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign fifo_write_enb = accept;
    assign fifo_datain    = req_data[owner*DATA_W +: DATA_W];
    assign gnt            = accept ? (NUM_REQ'(1) << owner) : '0;
    assign busy           = (state == ST_LOCKED);

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 32'(NUM_REQ); i++) begin
                if (stats_clr)
                    cnt[i] <= '0;
                else if (gnt[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign beat_count = cnt;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter; covers the stats counters when FIFO_ARB_STATS_EN is defined.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  gnt;
    logic        fifo_write_enb;
    logic [7:0]  fifo_datain;
    logic        fifo_full;
    logic        busy;
    logic [1:0]  owner;
    logic        stats_clr;
    logic [3:0]  hold    = '0;
    logic [3:0]  src_vld = '0;
    logic [3:0]  g_s     = '0;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] beat_count;
`endif

    logic [8:0]  src_q [4][$];
    logic [9:0]  exp_q [$];
    int          wr_cyc_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_cnt = 0;

    assign req = src_vld & ~hold;

    fifo_write_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8)
`ifdef FIFO_ARB_STATS_EN
        ,
        .CNT_W   (4)
`endif
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_data       (req_data),
        .req_last       (req_last),
        .gnt            (gnt),
        .fifo_write_enb (fifo_write_enb),
        .fifo_datain    (fifo_datain),
        .fifo_full      (fifo_full),
        .busy           (busy),
        .owner          (owner)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr      (stats_clr),
        .beat_count     (beat_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic send(input int src, input logic [7:0] d, input logic last);
        src_q[src].push_back({last, d});
    endtask

    task automatic exp_beat(input int src, input logic [7:0] d);
        exp_q.push_back({2'(src), d});
    endtask

    function automatic bit pending();
        bit p = (exp_q.size() != 0);
        for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain();
        int n = 0;
        while (pending() && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n >= 500), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("write_wait_timeout", 32'(n >= 200), 0);
    endtask

    // Source model: beat retires when the grant seen before the edge was for it
    always @(posedge clk) begin
        logic [8:0] b;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (g_s[i] && src_q[i].size() > 0) src_q[i].delete(0);
            if (src_q[i].size() > 0) begin
                b                = src_q[i][0];
                src_vld[i]       = 1'b1;
                req_last[i]      = b[8];
                req_data[i*8+:8] = b[7:0];
            end else begin
                src_vld[i]  = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        logic [3:0] eg;
        g_s = gnt;
        if (reset_n && fifo_write_enb) begin
            wr_cnt++;
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                eg = 4'b0001 << e[9:8];
                check("fifo_datain", 32'(fifo_datain), 32'(e[7:0]));
                check("gnt", 32'(gnt), 32'(eg));
                check("owner", 32'(owner), 32'(e[9:8]));
                check("busy_on_write", 32'(busy), 1);
            end
        end
        if (fifo_full) check("write_while_full", 32'(fifo_write_enb), 0);
    end

    initial begin
        int base;
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        stats_clr = 1'b0;

        // all four sources hold single-beat packets through reset
        send(0, 8'h10, 1); send(1, 8'h11, 1); send(2, 8'h12, 1); send(3, 8'h13, 1);
        send(0, 8'h14, 1);
        exp_beat(0, 8'h10); exp_beat(1, 8'h11); exp_beat(2, 8'h12); exp_beat(3, 8'h13);
        exp_beat(0, 8'h14);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_seen", 32'(req), 32'hF);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_enb", 32'(fifo_write_enb), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);

        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("idle_bubble_enb", 32'(fifo_write_enb), 0);
        check("idle_bubble_busy", 32'(busy), 0);
        @(negedge clk);
        check("first_busy", 32'(busy), 1);
        check("first_owner", 32'(owner), 0);
        drain();
        check("rr_write_count", 32'(wr_cyc_q.size()), 5);
        for (int k = 1; k < wr_cyc_q.size(); k++)
            check("rr_grant_spacing", 32'(wr_cyc_q[k] - wr_cyc_q[k-1]), 2);

        // src2 three-beat packet with src0 waiting: last_owner=0 so src2 wins
        wr_cyc_q.delete();
        send(2, 8'hA1, 0); send(2, 8'hA2, 0); send(2, 8'hA3, 1); send(0, 8'h05, 1);
        exp_beat(2, 8'hA1); exp_beat(2, 8'hA2); exp_beat(2, 8'hA3); exp_beat(0, 8'h05);
        drain();
        check("pkt_write_count", 32'(wr_cyc_q.size()), 4);
        if (wr_cyc_q.size() == 4) begin
            check("pkt_contig_1", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 1);
            check("pkt_contig_2", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 1);
            check("pkt_handover", 32'(wr_cyc_q[3] - wr_cyc_q[2]), 2);
        end

        // full for 5 cycles after two beats of a four-beat packet
        base = wr_cnt;
        send(1, 8'hB0, 0); send(1, 8'hB1, 0); send(1, 8'hB2, 0); send(1, 8'hB3, 1);
        exp_beat(1, 8'hB0); exp_beat(1, 8'hB1); exp_beat(1, 8'hB2); exp_beat(1, 8'hB3);
        wait_writes(base + 2);
        @(posedge clk); #1 fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("full_busy", 32'(busy), 1);
            check("full_enb", 32'(fifo_write_enb), 0);
            check("full_gnt", 32'(gnt), 0);
        end
        @(posedge clk); #1 fifo_full = 1'b0;
        drain();
        check("full_total_writes", 32'(wr_cnt - base), 4);

        // owner gap with src1 requesting: last_owner=1 so src3 wins, no preemption
        base = wr_cnt;
        send(3, 8'hC0, 0); send(3, 8'hC1, 0); send(3, 8'hC2, 1); send(1, 8'h55, 1);
        exp_beat(3, 8'hC0); exp_beat(3, 8'hC1); exp_beat(3, 8'hC2); exp_beat(1, 8'h55);
        wait_writes(base + 1);
        @(posedge clk); #1 hold[3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("gap_gnt", 32'(gnt), 0);
            check("gap_busy", 32'(busy), 1);
            check("gap_owner", 32'(owner), 3);
        end
        @(posedge clk); #1 hold[3] = 1'b0;
        drain();

`ifdef FIFO_ARB_STATS_EN
        for (int k = 0; k < 20; k++) begin
            send(1, 8'(8'h60 + k), (k == 19));
            exp_beat(1, 8'(8'h60 + k));
        end
        drain();
        check("stats_saturate", 32'(beat_count[4 +: 4]), 15);
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        @(negedge clk);
        check("stats_clear", 32'(beat_count), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
